// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and presents
// {PC, PC+4, instruction} through a one-entry buffer, absorbing redirects and stalls.
module if_fetch_unit #(
    parameter int                  WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                stall,
    input  logic                stall_twice,
    input  logic                redirect,
    input  logic [WORD_LEN-1:0] redirect_pc,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] PC_out,
    output logic [WORD_LEN-1:0] PCplus4_out,
    output logic [WORD_LEN-1:0] Instruction_out,
    output logic                if_valid
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    localparam logic [WORD_LEN-1:0] ALIGN_MASK = {{(WORD_LEN-2){1'b1}}, 2'b00};
    localparam logic [WORD_LEN-1:0] WORD_STEP  = WORD_LEN'(4);

    fetch_state_t        state, state_next;
    logic [WORD_LEN-1:0] pc_q;
    logic [WORD_LEN-1:0] drain_addr;
    logic [WORD_LEN-1:0] buf_pc;
    logic [WORD_LEN-1:0] buf_ins;
    logic                buf_valid;
    logic                hold_cnt;
    logic                hold;
    logic                deliver;
    logic                fire;

    always_comb begin
        hold       = stall | stall_twice | hold_cnt;
        deliver    = buf_valid & ~hold & ~redirect;
        state_next = state;
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = ~buf_valid | deliver;
                // A request left hanging by a redirect must still be completed before refetching
                if (redirect && imem_req && !imem_ready)
                    state_next = DRAIN;
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
                if (imem_ready)
                    state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
        fire = (state == FETCH) & imem_req & imem_ready & ~redirect;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            drain_addr <= '0;
            buf_pc     <= '0;
            buf_ins    <= '0;
            buf_valid  <= 1'b0;
            hold_cnt   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == FETCH && state_next == DRAIN)
                drain_addr <= pc_q;
            if (redirect) begin
                buf_valid <= 1'b0;
                pc_q      <= redirect_pc & ALIGN_MASK;
                hold_cnt  <= 1'b0;
            end else begin
                hold_cnt <= stall_twice;
                if (fire) begin
                    buf_pc    <= pc_q;
                    buf_ins   <= imem_rdata;
                    buf_valid <= 1'b1;
                    pc_q      <= pc_q + WORD_STEP;
                end else if (deliver) begin
                    buf_valid <= 1'b0;
                end
            end
        end
    end

    assign if_valid        = buf_valid;
    assign PC_out          = buf_valid ? buf_pc : '0;
    assign PCplus4_out     = buf_valid ? buf_pc + WORD_STEP : '0;
    assign Instruction_out = buf_valid ? buf_ins : '0;

endmodule
